// File: rtl/rv32i_mem_stage.sv
// RV32I memory stage: registers the EX->MEM boundary, issues RAM/IO accesses, formats store lanes and extracts load data.
// Latency: 1 cycle for non-memory ops, >=2 cycles for loads/stores (ack-dependent, aborted after MAX_WAIT cycles).
// Backpressure: in_ready is low while an access is in flight; EX must hold its instruction until accepted.
//
// Ports: clk/reset (sync, active-high); in_* handshake and EX operands; mem_*/io_* request/ack buses
// sharing bus_we/bus_be/bus_addr/bus_wdata; registered WB outputs, bus_err/misalign_err pulses, df_* forwarding.
// Optional build macro: MISALIGN_TRAP_EN -- when defined, misaligned half/word accesses are not issued and
// retire immediately with misalign_err; when undefined misalign_err is constant 0.
module rv32i_mem_stage #(
    parameter int IO_SEL_BIT = 31,
    parameter int MAX_WAIT   = 15,
    parameter int WAIT_CW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] pc_in,
    input  logic [31:0] iw_in,
    input  logic [31:0] alu_in,
    input  logic [31:0] rs2_data_in,
    input  logic        wb_en_in,
    input  logic [4:0]  wb_reg_in,
    output logic        mem_req,
    output logic        io_req,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        mem_ack,
    input  logic        io_ack,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] io_rdata,
    output logic        out_valid,
    output logic [31:0] pc_out,
    output logic [31:0] iw_out,
    output logic [31:0] wb_data_out,
    output logic        wb_en_out,
    output logic [4:0]  wb_reg_out,
    output logic        bus_err,
    output logic        misalign_err,
    output logic        df_mem_enable,
    output logic [4:0]  df_mem_reg,
    output logic [31:0] df_mem_data
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    logic [0:0]         state;
    logic [WAIT_CW-1:0] wait_cnt;

    // Context of the access in flight, held until it retires.
    logic [31:0] pc_q;
    logic [31:0] iw_q;
    logic [4:0]  wb_reg_q;
    logic        wb_en_q;
    logic        sel_q;
    logic [1:0]  addr_lo_q;

    logic        accept;
    logic        in_is_mem;
    logic        in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;
    logic        ack_sel;
    logic        timeout;
    logic [31:0] rdata_sel;
    logic [31:0] rdata_shift;
    logic [31:0] ld_data;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid & in_ready;
    assign in_is_mem = (iw_in[6:0] == OP_LOAD) || (iw_in[6:0] == OP_STORE);

`ifdef MISALIGN_TRAP_EN
    assign in_misaligned = in_is_mem &&
                           (((iw_in[13:12] == 2'd1) && alu_in[0]) ||
                            ((iw_in[13:12] == 2'd2) && (alu_in[1:0] != 2'd0)));
`else
    assign in_misaligned = 1'b0;
`endif

    always_comb begin
        in_be    = 4'b1111;
        in_wdata = rs2_data_in;
        case (iw_in[13:12])
            2'd0: begin
                in_be    = 4'b0001 << alu_in[1:0];
                in_wdata = {4{rs2_data_in[7:0]}};
            end
            2'd1: begin
                in_be    = alu_in[1] ? 4'b1100 : 4'b0011;
                in_wdata = {2{rs2_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Only the selected target's ack counts; the other one may be busy with someone else.
    assign ack_sel = sel_q ? io_ack : mem_ack;
    assign timeout = (wait_cnt == WAIT_CW'(MAX_WAIT - 1));
    assign mem_req = (state == WAIT) & ~sel_q;
    assign io_req  = (state == WAIT) &  sel_q;

    always_comb begin
        rdata_sel   = sel_q ? io_rdata : mem_rdata;
        rdata_shift = rdata_sel >> {addr_lo_q, 3'b000};
        case (iw_q[13:12])
            2'd0:    ld_data = iw_q[14] ? {24'd0, rdata_shift[7:0]}
                                        : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            2'd1:    ld_data = iw_q[14] ? {16'd0, rdata_shift[15:0]}
                                        : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            default: ld_data = rdata_shift;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            pc_q         <= '0;
            iw_q         <= '0;
            wb_reg_q     <= '0;
            wb_en_q      <= 1'b0;
            sel_q        <= 1'b0;
            addr_lo_q    <= '0;
            bus_we       <= 1'b0;
            bus_be       <= '0;
            bus_addr     <= '0;
            bus_wdata    <= '0;
            out_valid    <= 1'b0;
            pc_out       <= '0;
            iw_out       <= '0;
            wb_data_out  <= '0;
            wb_en_out    <= 1'b0;
            wb_reg_out   <= '0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            bus_err      <= 1'b0;
            misalign_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && in_is_mem && !in_misaligned) begin
                        state     <= WAIT;
                        wait_cnt  <= '0;
                        pc_q      <= pc_in;
                        iw_q      <= iw_in;
                        wb_reg_q  <= wb_reg_in;
                        wb_en_q   <= wb_en_in;
                        sel_q     <= alu_in[IO_SEL_BIT];
                        addr_lo_q <= alu_in[1:0];
                        bus_we    <= (iw_in[6:0] == OP_STORE);
                        bus_be    <= in_be;
                        bus_addr  <= alu_in[31:2];
                        bus_wdata <= in_wdata;
                    end else if (accept) begin
                        // Non-memory op, or a trapped misaligned access that never reaches the bus.
                        out_valid    <= 1'b1;
                        pc_out       <= pc_in;
                        iw_out       <= iw_in;
                        wb_reg_out   <= wb_reg_in;
                        wb_data_out  <= alu_in;
                        wb_en_out    <= wb_en_in & ~in_misaligned;
                        misalign_err <= in_misaligned;
                    end
                end
                default: begin
                    if (ack_sel || timeout) begin
                        state      <= IDLE;
                        wait_cnt   <= '0;
                        out_valid  <= 1'b1;
                        pc_out     <= pc_q;
                        iw_out     <= iw_q;
                        wb_reg_out <= wb_reg_q;
                        // Ack wins over a coinciding timeout.
                        bus_err    <= ~ack_sel;
                        wb_en_out  <= ack_sel & wb_en_q & (iw_q[6:0] == OP_LOAD);
                        if (ack_sel && (iw_q[6:0] == OP_LOAD))
                            wb_data_out <= ld_data;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign df_mem_enable = out_valid & wb_en_out;
    assign df_mem_reg    = wb_reg_out;
    assign df_mem_data   = wb_data_out;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
module tb_rv32i_mem_stage;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
    logic        wb_en_in;
    logic [4:0]  wb_reg_in;
    logic        mem_req, io_req, bus_we;
    logic [3:0]  bus_be;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        mem_ack, io_ack;
    logic [31:0] mem_rdata, io_rdata;
    logic        out_valid;
    logic [31:0] pc_out, iw_out, wb_data_out;
    logic        wb_en_out;
    logic [4:0]  wb_reg_out;
    logic        bus_err, misalign_err;
    logic        df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rv32i_mem_stage #(.IO_SEL_BIT(31), .MAX_WAIT(MAX_WAIT), .WAIT_CW(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
        .wb_en_in(wb_en_in), .wb_reg_in(wb_reg_in),
        .mem_req(mem_req), .io_req(io_req), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .mem_ack(mem_ack), .io_ack(io_ack), .mem_rdata(mem_rdata), .io_rdata(io_rdata),
        .out_valid(out_valid), .pc_out(pc_out), .iw_out(iw_out), .wb_data_out(wb_data_out),
        .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
        .bus_err(bus_err), .misalign_err(misalign_err),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference load result: pick the addressed bytes out of the word, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                               input int width, input logic uns);
        logic [31:0] v;
        v = rdata >> (8 * addr[1:0]);
        if (width == 0) begin
            v = v & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (width == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    // One instruction from offer to retirement. ack_at = WAIT cycle in which the target acks
    // (outside 1..MAX_WAIT means the target never answers).
    task automatic run_op(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic wen, input logic [4:0] wreg,
                          input int ack_at, input logic [31:0] rdata);
        logic is_ld, is_st, is_io, trap, tmo, done, uns;
        int   w, n_wait, exp_cycles;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_data;
        is_ld = (iw[6:0] == 7'b0000011);
        is_st = (iw[6:0] == 7'b0100011);
        is_io = alu[31];
        w     = int'(iw[13:12]);
        uns   = iw[14];
        trap  = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = (is_ld || is_st) && ((w == 1 && alu[0]) || (w == 2 && alu[1:0] != 2'd0));
`endif
        chk("in_ready_before", in_ready, 1);
        pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2; wb_en_in = wen; wb_reg_in = wreg;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        pc_in = $urandom; iw_in = $urandom; alu_in = $urandom; rs2_data_in = $urandom;
        if (!(is_ld || is_st) || trap) begin
            chk("nm_out_valid", out_valid, 1);
            chk("nm_wb_en", wb_en_out, wen & ~trap);
            chk("nm_wb_data", wb_data_out, alu);
            chk("nm_df_enable", df_mem_enable, wen & ~trap);
            chk("nm_misalign", misalign_err, trap);
            chk("nm_no_req", {mem_req, io_req}, 0);
            exp_data = alu;
        end else begin
            if (w == 0)      begin exp_be = 4'b0001 << alu[1:0]; exp_wd = {4{rs2[7:0]}}; end
            else if (w == 1) begin exp_be = alu[1] ? 4'b1100 : 4'b0011; exp_wd = {2{rs2[15:0]}}; end
            else             begin exp_be = 4'b1111; exp_wd = rs2; end
            tmo        = !(ack_at >= 1 && ack_at <= MAX_WAIT);
            exp_cycles = tmo ? MAX_WAIT : ack_at;
            n_wait = 0;
            done   = 1'b0;
            while (!done && n_wait < MAX_WAIT + 3) begin
                n_wait++;
                chk("mem_req", mem_req, !is_io);
                chk("io_req", io_req, is_io);
                chk("bus_we", bus_we, is_st);
                chk("bus_be", bus_be, exp_be);
                chk("bus_addr", bus_addr, alu[31:2]);
                if (is_st) chk("bus_wdata", bus_wdata, exp_wd);
                chk("in_ready_stall", in_ready, 0);
                chk("no_early_valid", out_valid, 0);
                // Noise on the unselected target must be ignored.
                if (is_io) begin
                    mem_ack = 1'($urandom); mem_rdata = $urandom;
                    io_ack = (n_wait == ack_at); io_rdata = rdata;
                end else begin
                    io_ack = 1'($urandom); io_rdata = $urandom;
                    mem_ack = (n_wait == ack_at); mem_rdata = rdata;
                end
                @(negedge clk);
                mem_ack = 1'b0; io_ack = 1'b0;
                if (out_valid) done = 1'b1;
            end
            chk("retired", done, 1);
            chk("wait_cycles", n_wait, exp_cycles);
            chk("bus_err", bus_err, tmo);
            chk("wb_en", wb_en_out, is_ld & wen & ~tmo);
            chk("df_enable", df_mem_enable, is_ld & wen & ~tmo);
            chk("misalign_mem", misalign_err, 0);
            if (is_ld && !tmo) chk("load_data", wb_data_out, model_load(rdata, alu, w, uns));
            exp_data = wb_data_out;
        end
        chk("pc_out", pc_out, pc);
        chk("iw_out", iw_out, iw);
        chk("wb_reg", df_mem_reg, wreg);
        @(negedge clk);
        chk("pulse_end", out_valid, 0);
        chk("df_pulse_end", df_mem_enable, 0);
        chk("data_hold", wb_data_out, exp_data);
        chk("req_idle", {mem_req, io_req}, 0);
    endtask

    initial begin
        int op, w;
        logic [31:0] iw, alu;
        reset = 1'b1; in_valid = 1'b0;
        pc_in = '0; iw_in = '0; alu_in = '0; rs2_data_in = '0; wb_en_in = 1'b0; wb_reg_in = '0;
        mem_ack = 1'b0; io_ack = 1'b0; mem_rdata = '0; io_rdata = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req", {mem_req, io_req}, 0);
        chk("rst_wb_data", wb_data_out, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_errs", {bus_err, misalign_err}, 0);

        // Directed cases.
        run_op(32'h100, 32'h00500293, 32'h1234, 32'h0, 1'b1, 5'd5, 0, 0);          // ADDI
        run_op(32'h104, 32'h00000083, 32'h103, 32'h0, 1'b1, 5'd1, 3, 32'h80FF7F01); // LB
        run_op(32'h108, 32'h00004083, 32'h103, 32'h0, 1'b1, 5'd1, 3, 32'h80FF7F01); // LBU
        run_op(32'h10C, 32'h00001023, 32'h80000002, 32'hAAAA5555, 1'b1, 5'd0, 1, 0); // SH to IO
        run_op(32'h110, 32'h00002083, 32'h40, 32'h0, 1'b1, 5'd2, 0, 32'h1);          // LW timeout
        run_op(32'h114, 32'h00002083, 32'h44, 32'h0, 1'b1, 5'd3, MAX_WAIT, 32'hCAFE); // ack on last cycle
        run_op(32'h118, 32'h00002083, 32'h6, 32'h0, 1'b1, 5'd4, 2, 32'h12345678);    // LW misaligned

        // Reset during the second WAIT cycle with a late ack.
        pc_in = 32'h200; iw_in = 32'h00002083; alu_in = 32'h80; wb_en_in = 1'b1; wb_reg_in = 5'd7;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h5A5A5A5A;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_req", {mem_req, io_req}, 0);
        chk("rstw_out_valid", out_valid, 0);
        chk("rstw_wb_en", wb_en_out, 0);
        run_op(32'h204, 32'h00000013, 32'h77, 32'h0, 1'b1, 5'd9, 0, 0);
        mem_ack = 1'b0;

        // Randomized mix of ALU ops, loads and stores to both targets.
        for (int i = 0; i < 150; i++) begin
            op  = $urandom_range(0, 2);
            w   = $urandom_range(0, 2);
            iw  = $urandom;
            iw[6:0]   = (op == 0) ? 7'b0010011 : (op == 1) ? 7'b0000011 : 7'b0100011;
            iw[13:12] = 2'(w);
            alu = $urandom;
            run_op($urandom, iw, alu, $urandom, 1'($urandom), 5'($urandom),
                   $urandom_range(0, MAX_WAIT + 1), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
